// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
// ----------------
// Receiving end of the motor PWM link. The PWM line is synchronised into the
// PWMClock domain, its high time and period are measured in clock cycles, and
// the 12-bit command value (high time minus Offset, clamped to 0..4095) is
// recovered. Each completed period is reported with a one-cycle DecodeValid
// strobe. A line with no edge for TimeoutCycles cycles is flagged as stuck.
//
// Optional build macro: PWM_GLITCH_FILTER_EN
//   defined   : a 3-sample stability filter follows the synchroniser; pulses of
//               1-2 cycles are ignored; edges are detected 6 cycles after PWMin.
//   undefined : raw synchronised level; edges detected 3 cycles after PWMin.
//
// Ports
//   PWMClock     in   system clock (50 MHz)
//   PWMReset     in   asynchronous active-high reset
//   PWMin        in   asynchronous PWM line
//   HighCount    out  [12:0] high cycles of the last completed period
//   PeriodCount  out  [12:0] rising-to-rising cycles of the last completed period
//   DecodedInput out  [11:0] recovered command value
//   DecodeValid  out  one-cycle strobe; all outputs update in that cycle
//   Stuck        out  line has had no edge for TimeoutCycles cycles
//   StuckLevel   out  synchronised line level when Stuck was set
//
// Handshake: DecodeValid is a push-only strobe (no ready). The data outputs
// change only in the cycle DecodeValid is high and hold between strobes.
module pwm_duty_decoder #(
  parameter int Offset        = 1514,
  parameter int TimeoutCycles = 8000
) (
  input  logic        PWMClock,
  input  logic        PWMReset,
  input  logic        PWMin,
  output logic [12:0] HighCount,
  output logic [12:0] PeriodCount,
  output logic [11:0] DecodedInput,
  output logic        DecodeValid,
  output logic        Stuck,
  output logic        StuckLevel
);

  localparam logic [12:0] CNT_MAX  = 13'h1FFF;
  localparam logic [12:0] TIMEOUT  = 13'(TimeoutCycles);
  localparam logic [13:0] OFFSET14 = 14'(Offset);

  typedef enum logic [1:0] {ST_WAIT, ST_HIGH, ST_LOW} state_t;

  // ---------------- input path ----------------
  logic sync1_q, sync2_q;
  logic level;
  logic prev_q;
  logic [2:0] settle_q;
  logic edge_en;
  logic rise, fall;

  always_ff @(posedge PWMClock or posedge PWMReset) begin
    if (PWMReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PWMin;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam logic [2:0] SETTLE = 3'd6;
  logic [1:0] hist_q;
  logic       filt_q;

  // Filtered level follows the synchronised level only after three
  // consecutive equal samples.
  always_ff @(posedge PWMClock or posedge PWMReset) begin
    if (PWMReset) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      if ((sync2_q == hist_q[0]) && (hist_q[0] == hist_q[1])) begin
        filt_q <= sync2_q;
      end
    end
  end

  assign level = filt_q;
`else
  localparam logic [2:0] SETTLE = 3'd3;
  assign level = sync2_q;
`endif

  // Edges are masked until the pipeline holds real samples of PWMin; otherwise
  // a line already high at reset release would look like a fresh rise and the
  // first report would cover a partial period.
  always_ff @(posedge PWMClock or posedge PWMReset) begin
    if (PWMReset) begin
      prev_q   <= 1'b0;
      settle_q <= 3'd0;
    end else begin
      prev_q <= level;
      if (settle_q != SETTLE) begin
        settle_q <= settle_q + 3'd1;
      end
    end
  end

  assign edge_en = (settle_q == SETTLE);
  assign rise    = edge_en & level & ~prev_q;
  assign fall    = edge_en & ~level & prev_q;

  // ---------------- measurement FSM ----------------
  state_t      state_q, state_d;
  logic [12:0] high_q, high_d;
  logic [12:0] per_q, per_d;
  logic [12:0] hc_q, hc_d;
  logic [12:0] pc_q, pc_d;
  logic [11:0] dec_q, dec_d;
  logic        valid_q, valid_d;
  logic        stuck_q, stuck_d;
  logic        lvl_q, lvl_d;
  logic        reported_q, reported_d;

  function automatic logic [12:0] sat_inc(input logic [12:0] x);
    return (x == CNT_MAX) ? x : x + 13'd1;
  endfunction

  function automatic logic [11:0] clamp_dec(input logic [12:0] h);
    logic [13:0] diff;
    diff = {1'b0, h} - OFFSET14;
    if ({1'b0, h} <= OFFSET14) return 12'd0;
    else if (diff > 14'd4095)  return 12'hFFF;
    else                       return diff[11:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    per_d      = per_q;
    hc_d       = hc_q;
    pc_d       = pc_q;
    dec_d      = dec_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;
    lvl_d      = lvl_q;
    reported_d = reported_q;

    unique case (state_q)
      ST_WAIT: begin
        if (rise) begin
          state_d = ST_HIGH;
          high_d  = 13'd1;
          per_d   = 13'd1;
          stuck_d = 1'b0;
        end else if (reported_q && !stuck_q) begin
          if (per_q >= TIMEOUT) begin
            valid_d = 1'b1;
            hc_d    = 13'd0;
            pc_d    = 13'd0;
            dec_d   = level ? 12'hFFF : 12'd0;
            stuck_d = 1'b1;
            lvl_d   = level;
            per_d   = 13'd0;
          end else begin
            per_d = sat_inc(per_q);
          end
        end
      end
      ST_HIGH: begin
        if (fall) begin
          // High counter freezes on the cycle the fall is seen.
          state_d = ST_LOW;
          per_d   = sat_inc(per_q);
        end else if (per_q >= TIMEOUT) begin
          valid_d = 1'b1;
          hc_d    = 13'd0;
          pc_d    = 13'd0;
          dec_d   = level ? 12'hFFF : 12'd0;
          stuck_d = 1'b1;
          lvl_d   = level;
          state_d = ST_WAIT;
          high_d  = 13'd0;
          per_d   = 13'd0;
        end else begin
          high_d = sat_inc(high_q);
          per_d  = sat_inc(per_q);
        end
      end
      ST_LOW: begin
        // A rise beats a timeout on the same cycle.
        if (rise) begin
          valid_d    = 1'b1;
          hc_d       = high_q;
          pc_d       = per_q;
          dec_d      = clamp_dec(high_q);
          reported_d = 1'b1;
          state_d    = ST_HIGH;
          high_d     = 13'd1;
          per_d      = 13'd1;
        end else if (per_q >= TIMEOUT) begin
          valid_d = 1'b1;
          hc_d    = 13'd0;
          pc_d    = 13'd0;
          dec_d   = level ? 12'hFFF : 12'd0;
          stuck_d = 1'b1;
          lvl_d   = level;
          state_d = ST_WAIT;
          high_d  = 13'd0;
          per_d   = 13'd0;
        end else begin
          per_d = sat_inc(per_q);
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge PWMClock or posedge PWMReset) begin
    if (PWMReset) begin
      state_q    <= ST_WAIT;
      high_q     <= 13'd0;
      per_q      <= 13'd0;
      hc_q       <= 13'd0;
      pc_q       <= 13'd0;
      dec_q      <= 12'd0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
      lvl_q      <= 1'b0;
      reported_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_q     <= high_d;
      per_q      <= per_d;
      hc_q       <= hc_d;
      pc_q       <= pc_d;
      dec_q      <= dec_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
      lvl_q      <= lvl_d;
      reported_q <= reported_d;
    end
  end

  assign HighCount    = hc_q;
  assign PeriodCount  = pc_q;
  assign DecodedInput = dec_q;
  assign DecodeValid  = valid_q;
  assign Stuck        = stuck_q;
  assign StuckLevel   = lvl_q;

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receiving end of the motor PWM link: samples a PWM line in the PWMClock domain and measures high time and period in clock cycles.
- Recovers the 12-bit command value that produced the waveform (high time minus Offset).
- Intended for loop-back checking of the motor PWM output and for decoding external PWM sources (throttle, controller feedback).
- Reports each completed period with a one-cycle valid strobe, and flags a stuck line after a timeout.

Parameters:
- Offset, 1514, floor subtracted from measured high time to recover the command value.
- TimeoutCycles, 8000, cycles without an edge before the line is declared stuck; must be in 1..8190.

Ports:
- PWMClock  input  1  system clock, 50 MHz.
- PWMReset  input  1  asynchronous active-high reset.
- PWMin  input  1  asynchronous PWM line to be decoded.
- HighCount  output  13  high cycles of the last completed period.
- PeriodCount  output  13  rising-to-rising cycles of the last completed period.
- DecodedInput  output  12  recovered command value.
- DecodeValid  output  1  one-cycle strobe; all outputs updated in the same cycle.
- Stuck  output  1  line has had no edge for TimeoutCycles.
- StuckLevel  output  1  synchronized level of the line when Stuck was set.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state WAIT, counters 0, synchronizer flops 0.
- Input path:
  - Two-flop synchronizer, then one edge-detect register.
  - Rise/fall detect is 3 cycles after the PWMin transition.
- States:
  - WAIT: ignore everything until the first detected rise, then go to HIGH with both counters = 1. The first partial period after reset or after stuck is never reported.
  - HIGH: both counters increment each cycle. On a detected fall, go to LOW (high counter freezes; period counter keeps counting).
  - LOW: period counter increments. On a detected rise, report, then go to HIGH with both counters restarted at 1.
- Report (the cycle after the detected rise):
  - DecodeValid = 1 for exactly one cycle.
  - HighCount and PeriodCount take the frozen values.
  - DecodedInput = HighCount − Offset, clamped to the range 0..4095; HighCount ≤ Offset gives 0.
- Counters saturate at 8191 and never wrap.
- Stuck (when the period counter reaches TimeoutCycles in HIGH or LOW, or no rise arrives within TimeoutCycles while in WAIT after the first report):
  - Stuck = 1, StuckLevel = current synchronized level.
  - One DecodeValid pulse with HighCount/PeriodCount = 0 and DecodedInput = 4095 if the line is high, 0 if low.
  - State returns to WAIT.
  - Stuck clears, with no extra pulse, on the first subsequent detected rise.
- Simultaneous events:
  - A rise on the same cycle as the timeout: the rise wins and a normal report is made.
  - A fall and a rise can never be detected on the same cycle.
- Output hold: outputs hold their last reported values between strobes.
- Reset mid-measurement: the in-progress period is discarded; no strobe is issued.

Optional Feature:
- Macro: PWM_GLITCH_FILTER_EN.
- When defined:
  - A 3-cycle majority/stability filter sits after the synchronizer; the filtered level changes only after 3 consecutive equal samples.
  - Pulses of 1–2 cycles are ignored.
  - Edge latency becomes 6 cycles.
- When undefined: raw synchronized level, 3-cycle latency, every pulse of ≥1 cycle counted.

Test Plan:
- Ideal waveform, high 2514 / period 5610 cycles, repeated 3 times:
  - No strobe for the first partial period.
  - Then strobes every 5610 cycles with HighCount=2514, PeriodCount=5610, DecodedInput=1000, Stuck=0.
- Clamping:
  - High 1200 / period 5610 → DecodedInput=0.
  - High 5609 / period 5610 → DecodedInput=4095.
  - High 1515 → DecodedInput=1.
- Stuck high:
  - Hold PWMin=1 for 9000 cycles after a valid period.
  - Stuck=1, StuckLevel=1, one strobe with DecodedInput=4095, outputs 0 for counts.
  - Stuck then clears on the next rise; the next full period is reported normally.
- Reset mid-period: assert PWMReset for 1 cycle at cycle 1000 of a HIGH phase → all outputs 0 immediately; first strobe only after a full new period.
- Glitch (PWM_GLITCH_FILTER_EN defined):
  - Inject a 2-cycle low pulse inside the high phase → HighCount unchanged at 2514.
  - With the macro undefined, the same stimulus gives a report with a shortened high time.
